// File: rtl/rv64_pkg.sv
// Shared definitions for the RV64 back end: opcode classes, queue geometry
// and default field widths used by the issue queue and its entries.
package rv64_pkg;

  // Queue geometry
  localparam int IQ_DEPTH     = 16;
  localparam int IQ_IDX_WIDTH = 4;
  localparam int IQ_CNT_WIDTH = 5;

  // Default field widths
  localparam int RV_OPCODE_WIDTH  = 7;
  localparam int RV_AGE_WIDTH     = 5;
  localparam int RV_TAG_WIDTH     = 6;
  localparam int RV_PAYLOAD_WIDTH = 64;

  // Opcode class constants (major opcode encodings)
  localparam logic [RV_OPCODE_WIDTH-1:0] R_TYPE      = 7'h33;
  localparam logic [RV_OPCODE_WIDTH-1:0] I_TYPE      = 7'h13;
  localparam logic [RV_OPCODE_WIDTH-1:0] LOAD_TYPE   = 7'h03;
  localparam logic [RV_OPCODE_WIDTH-1:0] STORE_TYPE  = 7'h23;
  localparam logic [RV_OPCODE_WIDTH-1:0] BRANCH_TYPE = 7'h63;
  localparam logic [RV_OPCODE_WIDTH-1:0] JAL_TYPE    = 7'h6f;
  localparam logic [RV_OPCODE_WIDTH-1:0] LUI_TYPE    = 7'h37;

  // Index of the lowest-numbered invalid entry. Callers only use the result
  // when at least one entry is free (count below depth).
  function automatic logic [IQ_IDX_WIDTH-1:0] lowest_free(
    input logic [IQ_DEPTH-1:0] valid
  );
    logic [IQ_IDX_WIDTH-1:0] idx;
    idx = '0;
    for (int i = IQ_DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) idx = IQ_IDX_WIDTH'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/iq_entry.sv
// One issue-queue slot: holds the instruction, its source tags/ready bits
// and its relative age. Wakes itself up on matching writebacks and closes
// the age gap when an older entry issues.
module iq_entry
  import rv64_pkg::*;
#(
  parameter int OPCODE_WIDTH  = RV_OPCODE_WIDTH,
  parameter int AGE_WIDTH     = RV_AGE_WIDTH,
  parameter int TAG_WIDTH     = RV_TAG_WIDTH,
  parameter int PAYLOAD_WIDTH = RV_PAYLOAD_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     alloc,
  input  logic [OPCODE_WIDTH-1:0]  alloc_op,
  input  logic [PAYLOAD_WIDTH-1:0] alloc_payload,
  input  logic [TAG_WIDTH-1:0]     alloc_src1_tag,
  input  logic [TAG_WIDTH-1:0]     alloc_src2_tag,
  input  logic                     alloc_src1_rdy,
  input  logic                     alloc_src2_rdy,
  input  logic [AGE_WIDTH-1:0]     alloc_age,
  input  logic                     wb_valid,
  input  logic [TAG_WIDTH-1:0]     wb_tag,
  input  logic                     issue_fire,
  input  logic                     issue_sel,
  input  logic [AGE_WIDTH-1:0]     issue_age,
  output logic                     valid,
  output logic                     req,
  output logic [OPCODE_WIDTH-1:0]  op,
  output logic [AGE_WIDTH-1:0]     age,
  output logic [PAYLOAD_WIDTH-1:0] payload
);

  logic                     valid_reg, valid_next;
  logic [OPCODE_WIDTH-1:0]  op_reg, op_next;
  logic [PAYLOAD_WIDTH-1:0] payload_reg, payload_next;
  logic [TAG_WIDTH-1:0]     src1_tag_reg, src1_tag_next;
  logic [TAG_WIDTH-1:0]     src2_tag_reg, src2_tag_next;
  logic                     src1_rdy_reg, src1_rdy_next;
  logic                     src2_rdy_reg, src2_rdy_next;
  logic [AGE_WIDTH-1:0]     age_reg, age_next;

  // Writeback tag comparators for the held sources and for a same-cycle
  // dispatch into this slot.
  logic wake1, wake2, alloc_wake1, alloc_wake2;
  assign wake1       = wb_valid && (wb_tag == src1_tag_reg);
  assign wake2       = wb_valid && (wb_tag == src2_tag_reg);
  assign alloc_wake1 = wb_valid && (wb_tag == alloc_src1_tag);
  assign alloc_wake2 = wb_valid && (wb_tag == alloc_src2_tag);

  // Next-state: flush beats allocate beats issue/wakeup/age compaction.
  always_comb begin
    valid_next    = valid_reg;
    op_next       = op_reg;
    payload_next  = payload_reg;
    src1_tag_next = src1_tag_reg;
    src2_tag_next = src2_tag_reg;
    src1_rdy_next = src1_rdy_reg;
    src2_rdy_next = src2_rdy_reg;
    age_next      = age_reg;
    if (flush) begin
      valid_next    = 1'b0;
      src1_rdy_next = 1'b0;
      src2_rdy_next = 1'b0;
      age_next      = '0;
    end else if (alloc) begin
      valid_next    = 1'b1;
      op_next       = alloc_op;
      payload_next  = alloc_payload;
      src1_tag_next = alloc_src1_tag;
      src2_tag_next = alloc_src2_tag;
      src1_rdy_next = alloc_src1_rdy | alloc_wake1;
      src2_rdy_next = alloc_src2_rdy | alloc_wake2;
      age_next      = alloc_age;
    end else if (valid_reg) begin
      if (issue_fire && issue_sel) begin
        valid_next    = 1'b0;
        src1_rdy_next = 1'b0;
        src2_rdy_next = 1'b0;
        age_next      = '0;
      end else begin
        if (wake1) src1_rdy_next = 1'b1;
        if (wake2) src2_rdy_next = 1'b1;
        // Younger than the departing entry: slide down to keep ages dense.
        if (issue_fire && (age_reg > issue_age)) age_next = age_reg - 1'b1;
      end
    end
  end

  // State register; only control and age need a defined reset value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg    <= 1'b0;
      src1_rdy_reg <= 1'b0;
      src2_rdy_reg <= 1'b0;
      age_reg      <= '0;
    end else begin
      valid_reg    <= valid_next;
      src1_rdy_reg <= src1_rdy_next;
      src2_rdy_reg <= src2_rdy_next;
      age_reg      <= age_next;
    end
    op_reg       <= op_next;
    payload_reg  <= payload_next;
    src1_tag_reg <= src1_tag_next;
    src2_tag_reg <= src2_tag_next;
  end

  // Invalid slots present zeros so arbiters never see stale fields.
  assign valid   = valid_reg;
  assign req     = valid_reg & src1_rdy_reg & src2_rdy_reg;
  assign op      = valid_reg ? op_reg : '0;
  assign age     = valid_reg ? age_reg : '0;
  assign payload = valid_reg ? payload_reg : '0;

endmodule

// File: rtl/issue_queue16.sv
// 16-entry out-of-order issue queue. Allocates into the lowest free slot,
// exports per-entry op/request/age vectors to external age-based arbiters,
// and registers the granted entry's payload toward execution.
module issue_queue16
  import rv64_pkg::*;
#(
  parameter int OPCODE_WIDTH  = RV_OPCODE_WIDTH,
  parameter int AGE_WIDTH     = RV_AGE_WIDTH,
  parameter int TAG_WIDTH     = RV_TAG_WIDTH,
  parameter int PAYLOAD_WIDTH = RV_PAYLOAD_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             disp_valid,
  output logic                             disp_ready,
  input  logic [OPCODE_WIDTH-1:0]          disp_op,
  input  logic [PAYLOAD_WIDTH-1:0]         disp_payload,
  input  logic [TAG_WIDTH-1:0]             disp_src1_tag,
  input  logic [TAG_WIDTH-1:0]             disp_src2_tag,
  input  logic                             disp_src1_rdy,
  input  logic                             disp_src2_rdy,
  input  logic                             wb_valid,
  input  logic [TAG_WIDTH-1:0]             wb_tag,
  output logic [IQ_DEPTH*OPCODE_WIDTH-1:0] iq_op,
  output logic [IQ_DEPTH-1:0]              iq_req,
  output logic [IQ_DEPTH*AGE_WIDTH-1:0]    iq_age,
  input  logic                             issue_grant,
  input  logic [IQ_IDX_WIDTH-1:0]          issue_addr,
  output logic                             issue_valid,
  output logic [OPCODE_WIDTH-1:0]          issue_op,
  output logic [PAYLOAD_WIDTH-1:0]         issue_payload,
  output logic [IQ_CNT_WIDTH-1:0]          count
);

  logic [IQ_DEPTH-1:0]      valid_vec;
  logic [IQ_DEPTH-1:0]      req_vec;
  logic [OPCODE_WIDTH-1:0]  op_arr      [IQ_DEPTH];
  logic [AGE_WIDTH-1:0]     age_arr     [IQ_DEPTH];
  logic [PAYLOAD_WIDTH-1:0] payload_arr [IQ_DEPTH];

  logic [IQ_CNT_WIDTH-1:0]  count_reg, count_next;
  logic                     issue_valid_reg, issue_valid_next;
  logic [OPCODE_WIDTH-1:0]  issue_op_reg, issue_op_next;
  logic [PAYLOAD_WIDTH-1:0] issue_payload_reg, issue_payload_next;

  logic                     accept;
  logic                     issue_fire;
  logic [IQ_IDX_WIDTH-1:0]  alloc_idx;
  logic [AGE_WIDTH-1:0]     issue_age;
  logic [AGE_WIDTH-1:0]     new_age;

  // Ready depends only on registered occupancy; a slot freed this cycle is
  // not reusable until the next one.
  assign disp_ready = (count_reg != IQ_CNT_WIDTH'(IQ_DEPTH));
  assign accept     = disp_valid & disp_ready & ~flush;
  assign alloc_idx  = lowest_free(valid_vec);

  // A grant to a non-requesting entry is dropped without side effects.
  assign issue_fire = issue_grant & req_vec[issue_addr] & ~flush;
  assign issue_age  = age_arr[issue_addr];

  // The newcomer is youngest; an issue this cycle shifts everyone down one.
  assign new_age = issue_fire ? AGE_WIDTH'(count_reg - 1'b1) : AGE_WIDTH'(count_reg);

  genvar gi;
  generate
    for (gi = 0; gi < IQ_DEPTH; gi++) begin : g_entry
      iq_entry #(
        .OPCODE_WIDTH  (OPCODE_WIDTH),
        .AGE_WIDTH     (AGE_WIDTH),
        .TAG_WIDTH     (TAG_WIDTH),
        .PAYLOAD_WIDTH (PAYLOAD_WIDTH)
      ) u_entry (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .alloc          (accept && (alloc_idx == IQ_IDX_WIDTH'(gi))),
        .alloc_op       (disp_op),
        .alloc_payload  (disp_payload),
        .alloc_src1_tag (disp_src1_tag),
        .alloc_src2_tag (disp_src2_tag),
        .alloc_src1_rdy (disp_src1_rdy),
        .alloc_src2_rdy (disp_src2_rdy),
        .alloc_age      (new_age),
        .wb_valid       (wb_valid),
        .wb_tag         (wb_tag),
        .issue_fire     (issue_fire),
        .issue_sel      (issue_addr == IQ_IDX_WIDTH'(gi)),
        .issue_age      (issue_age),
        .valid          (valid_vec[gi]),
        .req            (req_vec[gi]),
        .op             (op_arr[gi]),
        .age            (age_arr[gi]),
        .payload        (payload_arr[gi])
      );

      assign iq_op[gi*OPCODE_WIDTH +: OPCODE_WIDTH] = op_arr[gi];
      assign iq_age[gi*AGE_WIDTH +: AGE_WIDTH]      = age_arr[gi];
    end
  endgenerate

  assign iq_req = req_vec;

  // Occupancy: dispatch and issue in the same cycle cancel out.
  always_comb begin
    count_next = count_reg;
    if (flush) begin
      count_next = '0;
    end else if (accept && !issue_fire) begin
      count_next = count_reg + 1'b1;
    end else if (!accept && issue_fire) begin
      count_next = count_reg - 1'b1;
    end
  end

  // Issue output: strobe for one cycle per accepted grant, hold data otherwise.
  always_comb begin
    issue_valid_next   = 1'b0;
    issue_op_next      = issue_op_reg;
    issue_payload_next = issue_payload_reg;
    if (issue_fire) begin
      issue_valid_next   = 1'b1;
      issue_op_next      = op_arr[issue_addr];
      issue_payload_next = payload_arr[issue_addr];
    end
  end

  // Count and issue output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg         <= '0;
      issue_valid_reg   <= 1'b0;
      issue_op_reg      <= '0;
      issue_payload_reg <= '0;
    end else begin
      count_reg         <= count_next;
      issue_valid_reg   <= issue_valid_next;
      issue_op_reg      <= issue_op_next;
      issue_payload_reg <= issue_payload_next;
    end
  end

  assign count         = count_reg;
  assign issue_valid   = issue_valid_reg;
  assign issue_op      = issue_op_reg;
  assign issue_payload = issue_payload_reg;

endmodule

// File: doc/issue_queue16.md
# issue_queue16

16-entry out-of-order issue queue that feeds the age-based oldest-first arbiter. Accepts dispatched instructions, tracks source-operand readiness via writeback tag wakeup, and keeps a compact relative age per entry. Drives per-entry op/request/age vectors to one or more arbiters. Removes the entry at the granted address and registers its payload toward the execution unit.

## Interface
- OPCODE_WIDTH, 7, opcode width; matches the arbiter's op compare
- AGE_WIDTH, 5, age field width; ages range 0..15, and 0 is the oldest
- TAG_WIDTH, 6, physical register tag width
- PAYLOAD_WIDTH, 64, opaque instruction payload width
- clk  in  1  clock; one clock domain
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  synchronous squash of all entries
- disp_valid  in  1  dispatch request
- disp_ready  out  1  queue can accept; equals (count != 16)
- disp_op  in  OPCODE_WIDTH  instruction opcode class
- disp_payload  in  PAYLOAD_WIDTH  instruction payload
- disp_src1_tag, disp_src2_tag  in  TAG_WIDTH  source tags
- disp_src1_rdy, disp_src2_rdy  in  1  source already available
- wb_valid  in  1  writeback broadcast
- wb_tag  in  TAG_WIDTH  tag that becomes ready
- iq_op  out  16*OPCODE_WIDTH  per-entry opcode, entry i at [i*OPCODE_WIDTH +: OPCODE_WIDTH]
- iq_req  out  16  per-entry request = valid & src1_rdy & src2_rdy
- iq_age  out  16*AGE_WIDTH  per-entry age, packed the same way as iq_op
- issue_grant  in  1  arbiter grant
- issue_addr  in  4  granted entry index
- issue_valid  out  1  registered issue strobe
- issue_op  out  OPCODE_WIDTH  registered opcode of the issued entry
- issue_payload  out  PAYLOAD_WIDTH  registered payload of the issued entry
- count  out  5  occupancy, 0..16

## Operation
- **Allocation:** when disp_valid & disp_ready, write the lowest-index invalid entry; valid is set at the next edge.
- **Age invariant:** valid entries always hold distinct ages 0..count-1, in program order.
- **Age of a new entry, no issue this cycle:** count.
- **Age of a new entry, with an accepted grant this cycle:** count-1.
- **Issue:** when issue_grant is high, entry issue_addr is invalidated at the next edge.
  - Every valid entry with age greater than the issued entry's age decrements by 1 in the same edge.
  - Ages never wrap.
- **Illegal grant:** issue_grant to an entry with iq_req[issue_addr]=0 is illegal. The bench asserts on it; the RTL ignores the grant (no state change, issue_valid stays 0).
- **Wakeup:**
  - An entry's srcN_rdy sets at the next edge when wb_valid and wb_tag == srcN_tag.
  - A dispatching instruction whose source tag matches the same-cycle wb_tag is written with that rdy already set.
  - Ready bits only ever clear on reset, flush or issue.
- **Occupancy:** count increments on dispatch, decrements on issue, and is unchanged when both happen in the same cycle.
- **disp_ready:** combinational from the registered count only. There is no same-cycle bypass of a freed slot.
- **Flush:** clears all valid bits, ready bits, ages and count, and forces issue_valid to 0 at the next edge. Flush has priority over dispatch, grant and wakeup in the same cycle.
- **Invalid entries:** drive iq_req=0, iq_age=0 and iq_op=0.

## Timing
- **Reset (rst_n low at an edge):**
  - All entries invalid; count=0.
  - iq_req=0, iq_age=0, iq_op=0.
  - issue_valid=0, issue_op=0, issue_payload=0.
  - disp_ready=1 from the first cycle after reset.
- **Dispatch to request:** an instruction dispatched in cycle N with both sources ready shows iq_req=1 in cycle N+1.
- **Wakeup to request:** a wakeup in cycle N shows iq_req=1 in cycle N+1.
- **Grant to issue:** the arbiter is combinational. A grant in cycle N produces issue_valid, issue_op and issue_payload in cycle N+1, and iq_req for that entry is 0 in N+1.
- **Full queue (count=16):** disp_ready=0 and dispatch is ignored, even if a grant frees a slot in the same cycle.
- **Empty queue:** iq_req=0; issue_valid drops to 0 the cycle after the last issue.
- **Reset or flush mid-dispatch:** the dispatch is dropped and disp_ready stays 1.

## Structure
- **Shared package (rv64_pkg):** opcode class constants (R_TYPE etc.), IQ_DEPTH=16, and the AGE_WIDTH and TAG_WIDTH defaults.
- **Sub-module iq_entry:** one entry holding valid, op, payload, tags, ready bits and age, with its own wakeup comparators and decrement logic.
  - The top instantiates 16 of them.
  - The top contains the free-entry priority encoder, the count register and the issue output register.
- **Arbiters:** instantiated by the parent. This block only exports the vectors.

## Test plan
- **Reset and fill:** after reset, dispatch 16 ready R_TYPE ops.
  - Expect ages 0..15 in entries 0..15 and count=16.
  - Expect disp_ready=0 after the 16th dispatch.
  - A 17th disp_valid is not accepted.
- **Age compaction:** with 4 entries holding ages 0..3, grant entry 1 (age 1).
  - Next cycle: issue_valid=1 with entry 1's payload.
  - Remaining ages are 0, 1, 2 and count=3.
- **Simultaneous dispatch and issue:** with count=3, dispatch one op and grant the age-0 entry in the same cycle.
  - Expect count=3; the new entry gets age 2 and lands in the lowest free index.
- **Wakeup:** dispatch with src1_tag=5 not ready, then pulse wb_valid with wb_tag=5 two cycles later.
  - iq_req rises exactly one cycle after the pulse.
  - In a second case, a same-cycle wb_tag=5 during dispatch gives iq_req=1 the next cycle.
- **Flush priority:** with count=8, assert flush together with dispatch and grant.
  - Next cycle: count=0, all iq_req=0, issue_valid=0.
- **Full-queue corner:** with count=16, grant one entry while disp_valid=1.
  - The dispatch is not accepted and count=15.
  - Next cycle disp_ready=1 and a dispatch gets age 15.
